// File: rtl/alarm_trigger.sv
`default_nettype none
// ============================================================================
// Module      : alarm_trigger
// Description : Latches the committed BCD MM:SS alarm value, matches it against
//               the running time on each 1 Hz tick, and drives ring/blink with
//               a timed ring window, dismiss, and optional snooze
//               (compiled in when ALARM_SNOOZE_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_trigger #(
  parameter int RING_SECONDS   = 30,
  parameter int SNOOZE_SECONDS = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        tick_1hz,
  input  logic [15:0] time_bcd,
  input  logic [15:0] alarm_bcd,
  input  logic        alarm_load,
  input  logic        push_c,
  input  logic        push_u,
  output logic        armed,
  output logic        ring,
  output logic        blink,
  output logic        snoozing,
  output logic [7:0]  remain,
  output logic        load_err,
  output logic [15:0] alarm_q
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_RINGING = 2'd2
`ifdef ALARM_SNOOZE_EN
    , S_SNOOZE = 2'd3
`endif
  } state_t;

  localparam logic [7:0] C_RING_TICKS = 8'(RING_SECONDS);
`ifdef ALARM_SNOOZE_EN
  localparam logic [7:0] C_SNOOZE_TICKS = 8'(SNOOZE_SECONDS);
`endif

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  w_next_remain;
  logic        w_next_blink;
  logic [15:0] w_next_alarm;
  logic        w_next_err;
  logic        w_alarm_valid;
  logic        w_match;
  logic        w_last_tick;

  // Tens digits of minutes and seconds only go up to 5.
  assign w_alarm_valid = (alarm_bcd[15:12] <= 4'd5) && (alarm_bcd[11:8] <= 4'd9) &&
                         (alarm_bcd[7:4]   <= 4'd5) && (alarm_bcd[3:0]  <= 4'd9);
  assign w_match       = tick_1hz && (time_bcd == alarm_q);
  assign w_last_tick   = (remain <= 8'd1);

  always_comb begin
    w_next_state  = r_state;
    w_next_remain = remain;
    w_next_blink  = blink;
    w_next_alarm  = alarm_q;
    w_next_err    = 1'b0;
    if (!enable) begin
      w_next_state  = S_IDLE;
      w_next_remain = 8'd0;
      w_next_blink  = 1'b0;
    end else if (alarm_load) begin
      // A rejected load consumes the cycle: nothing else changes.
      if (w_alarm_valid) begin
        w_next_alarm  = alarm_bcd;
        w_next_state  = S_ARMED;
        w_next_remain = 8'd0;
        w_next_blink  = 1'b0;
      end else begin
        w_next_err = 1'b1;
      end
    end else begin
      case (r_state)
        S_ARMED: begin
          if (w_match) begin
            w_next_state  = S_RINGING;
            w_next_remain = C_RING_TICKS;
            w_next_blink  = 1'b1;
          end
        end
        S_RINGING: begin
          if (push_c) begin
            w_next_state  = S_ARMED;
            w_next_remain = 8'd0;
            w_next_blink  = 1'b0;
          end
`ifdef ALARM_SNOOZE_EN
          else if (push_u) begin
            w_next_state  = S_SNOOZE;
            w_next_remain = C_SNOOZE_TICKS;
            w_next_blink  = 1'b0;
          end
`endif
          else if (tick_1hz) begin
            if (w_last_tick) begin
              w_next_state  = S_ARMED;
              w_next_remain = 8'd0;
              w_next_blink  = 1'b0;
            end else begin
              w_next_remain = remain - 8'd1;
              w_next_blink  = ~blink;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        S_SNOOZE: begin
          if (push_c) begin
            w_next_state  = S_ARMED;
            w_next_remain = 8'd0;
          end else if (tick_1hz) begin
            if (w_last_tick) begin
              w_next_state  = S_RINGING;
              w_next_remain = C_RING_TICKS;
              w_next_blink  = 1'b1;
            end else begin
              w_next_remain = remain - 8'd1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef ALARM_SNOOZE_EN
  logic r_snoozing;
  assign snoozing = r_snoozing;
`else
  logic w_unused_snooze;
  assign w_unused_snooze = push_u ^ SNOOZE_SECONDS[0];
  assign snoozing        = 1'b0;
`endif

  // Status flags are decoded from the next state so they register with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      remain     <= 8'd0;
      blink      <= 1'b0;
      armed      <= 1'b0;
      ring       <= 1'b0;
      load_err   <= 1'b0;
      alarm_q    <= 16'd0;
`ifdef ALARM_SNOOZE_EN
      r_snoozing <= 1'b0;
`endif
    end else begin
      r_state    <= w_next_state;
      remain     <= w_next_remain;
      blink      <= w_next_blink;
      armed      <= (w_next_state != S_IDLE);
      ring       <= (w_next_state == S_RINGING);
      load_err   <= w_next_err;
      alarm_q    <= w_next_alarm;
`ifdef ALARM_SNOOZE_EN
      r_snoozing <= (w_next_state == S_SNOOZE);
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alarm_trigger.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_trigger
// Description : Scoreboard bench for alarm_trigger (RING_SECONDS=30,
//               SNOOZE_SECONDS=3); snooze checks follow ALARM_SNOOZE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_trigger;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        tick_1hz = 1'b0;
  logic [15:0] time_bcd = 16'h0000;
  logic [15:0] alarm_bcd = 16'h0000;
  logic        alarm_load = 1'b0;
  logic        push_c = 1'b0;
  logic        push_u = 1'b0;
  logic        armed, ring, blink, snoozing, load_err;
  logic [7:0]  remain;
  logic [15:0] alarm_q;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic        armed;
    logic        ring;
    logic        blink;
    logic        snz;
    logic [7:0]  remain;
    logic        lerr;
    logic [15:0] aq;
  } exp_t;

  exp_t sb[$];

  alarm_trigger #(
    .RING_SECONDS  (30),
    .SNOOZE_SECONDS(3)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .tick_1hz  (tick_1hz),
    .time_bcd  (time_bcd),
    .alarm_bcd (alarm_bcd),
    .alarm_load(alarm_load),
    .push_c    (push_c),
    .push_u    (push_u),
    .armed     (armed),
    .ring      (ring),
    .blink     (blink),
    .snoozing  (snoozing),
    .remain    (remain),
    .load_err  (load_err),
    .alarm_q   (alarm_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic a, input logic r, input logic b,
                          input logic s, input logic [7:0] rem, input logic le,
                          input logic [15:0] aq);
    exp_t e;
    e.tag = tag; e.armed = a; e.ring = r; e.blink = b; e.snz = s;
    e.remain = rem; e.lerr = le; e.aq = aq;
    sb.push_back(e);
  endtask

  task automatic score();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, ".armed"},    32'(armed),    32'(e.armed));
      check({e.tag, ".ring"},     32'(ring),     32'(e.ring));
      check({e.tag, ".blink"},    32'(blink),    32'(e.blink));
      check({e.tag, ".snoozing"}, 32'(snoozing), 32'(e.snz));
      check({e.tag, ".remain"},   32'(remain),   32'(e.remain));
      check({e.tag, ".load_err"}, 32'(load_err), 32'(e.lerr));
      check({e.tag, ".alarm_q"},  32'(alarm_q),  32'(e.aq));
    end
  endtask

  // Clock the currently driven inputs in, then retire the one-clk pulses.
  task automatic step(input string tag, input logic a, input logic r, input logic b,
                      input logic s, input logic [7:0] rem, input logic le,
                      input logic [15:0] aq);
    push_exp(tag, a, r, b, s, rem, le, aq);
    @(posedge clk);
    #1;
    alarm_load = 1'b0;
    push_c     = 1'b0;
    push_u     = 1'b0;
    tick_1hz   = 1'b0;
    score();
  endtask

  task automatic now_exp(input string tag, input logic a, input logic r, input logic b,
                         input logic s, input logic [7:0] rem, input logic le,
                         input logic [15:0] aq);
    push_exp(tag, a, r, b, s, rem, le, aq);
    score();
  endtask

  initial begin
    #3;
    now_exp("reset", 0, 0, 0, 0, 8'd0, 0, 16'h0000);
    #9;
    reset  = 1'b0;
    enable = 1'b1;

    alarm_bcd = 16'h0105; alarm_load = 1'b1;
    step("load", 1, 0, 0, 0, 8'd0, 0, 16'h0105);
    time_bcd = 16'h0104; tick_1hz = 1'b1;
    step("tick0104", 1, 0, 0, 0, 8'd0, 0, 16'h0105);
    time_bcd = 16'h0105; tick_1hz = 1'b1;
    step("trigger", 1, 1, 1, 0, 8'd30, 0, 16'h0105);
    step("hold", 1, 1, 1, 0, 8'd30, 0, 16'h0105);

    for (int i = 1; i <= 30; i++) begin
      time_bcd = 16'h0106; tick_1hz = 1'b1;
      if (i < 30) step($sformatf("win%0d", i), 1, 1, ~i[0], 0, 8'(30 - i), 0, 16'h0105);
      else        step("timeout", 1, 0, 0, 0, 8'd0, 0, 16'h0105);
    end

    time_bcd = 16'h0105; tick_1hz = 1'b1;
    step("rering", 1, 1, 1, 0, 8'd30, 0, 16'h0105);

    alarm_bcd = 16'h0A00; alarm_load = 1'b1;
    step("bad0A00", 1, 1, 1, 0, 8'd30, 1, 16'h0105);
    step("err_drop1", 1, 1, 1, 0, 8'd30, 0, 16'h0105);
    alarm_bcd = 16'h0060; alarm_load = 1'b1;
    step("bad0060", 1, 1, 1, 0, 8'd30, 1, 16'h0105);
    step("err_drop2", 1, 1, 1, 0, 8'd30, 0, 16'h0105);

`ifdef ALARM_SNOOZE_EN
    push_u = 1'b1;
    step("snooze", 1, 0, 0, 1, 8'd3, 0, 16'h0105);
    tick_1hz = 1'b1; step("snz_t1", 1, 0, 0, 1, 8'd2, 0, 16'h0105);
    tick_1hz = 1'b1; step("snz_t2", 1, 0, 0, 1, 8'd1, 0, 16'h0105);
    tick_1hz = 1'b1; step("snz_end", 1, 1, 1, 0, 8'd30, 0, 16'h0105);
`else
    push_u = 1'b1;
    step("push_u_nop", 1, 1, 1, 0, 8'd30, 0, 16'h0105);
`endif
    push_c = 1'b1;
    step("dismiss", 1, 0, 0, 0, 8'd0, 0, 16'h0105);

    time_bcd = 16'h0105; tick_1hz = 1'b1;
    step("ring3", 1, 1, 1, 0, 8'd30, 0, 16'h0105);
    alarm_bcd = 16'h0230; alarm_load = 1'b1; push_c = 1'b1;
    step("load_dismiss", 1, 0, 0, 0, 8'd0, 0, 16'h0230);

    time_bcd = 16'h0230; tick_1hz = 1'b1;
    step("ring4", 1, 1, 1, 0, 8'd30, 0, 16'h0230);
    tick_1hz = 1'b1;
    step("no_retrigger", 1, 1, 0, 0, 8'd29, 0, 16'h0230);

    enable = 1'b0;
    step("disable", 0, 0, 0, 0, 8'd0, 0, 16'h0230);
    enable = 1'b1; tick_1hz = 1'b1;
    step("idle_tick", 0, 0, 0, 0, 8'd0, 0, 16'h0230);
    push_c = 1'b1; push_u = 1'b1;
    step("idle_push", 0, 0, 0, 0, 8'd0, 0, 16'h0230);

    alarm_bcd = 16'h0230; alarm_load = 1'b1;
    step("reload", 1, 0, 0, 0, 8'd0, 0, 16'h0230);
    tick_1hz = 1'b1;
    step("ring5", 1, 1, 1, 0, 8'd30, 0, 16'h0230);

    #2 reset = 1'b1;
    #1 now_exp("reset_mid", 0, 0, 0, 0, 8'd0, 0, 16'h0000);
    #1 reset = 1'b0;
    tick_1hz = 1'b1;
    step("post_reset_match", 0, 0, 0, 0, 8'd0, 0, 16'h0000);
    alarm_load = 1'b1;
    step("rearm", 1, 0, 0, 0, 8'd0, 0, 16'h0230);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
